// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: FSM states and frame constants shared by the PISO and SIPO shift stages.
package shift_reg_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  // Parity rides in the last-transmitted bit of the frame, which is bit 0 of the shift register.
  localparam int PARITY_POS = 0;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit index within a frame, cleared on load, terminal count at NBITS-1.
module piso_bit_counter #(
  parameter int NBITS = 8,
  parameter int CW = $clog2(NBITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == CW'(NBITS - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with zero-gap back-to-back words.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);
`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  state_t state_q, state_d;
  logic [NBITS-1:0] sreg_q, sreg_d, frame;
  logic [WIDTH-1:0] ordered;
  logic tc, last, accept, shifting;
  // The frame is stored in transmit order so the outgoing bit is always the MSB.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ord
    assign ordered[g] = MSB_FIRST ? load_data[g] : load_data[WIDTH-1-g];
  end
`ifdef PISO_PARITY_EN
  always_comb begin
    frame = {ordered, 1'b0};
    frame[PARITY_POS] = ^load_data;
  end
`else
  assign frame = ordered;
`endif
  assign shifting = state_q == SHIFT;
  assign last = shifting && tc;
  assign load_ready = !shifting || tc;
  assign accept = load_valid && load_ready;
  always_comb begin
    state_d = accept ? SHIFT : last ? IDLE : state_q;
    sreg_d = accept ? frame : shifting ? sreg_q << 1 : sreg_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
    end
  piso_bit_counter #(.NBITS(NBITS)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(accept || last),
    .inc (shifting && !tc),
    .tc  (tc)
  );
  assign dout = shifting && sreg_q[NBITS-1];
  assign dout_valid = shifting;
  assign busy = shifting;
  assign done = last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first and LSB-first instances checked against a bit-queue model.
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int NB = 9;
  localparam logic [31:0] B3_M = 32'h167, B3_L = 32'h19B, X01_M = 32'h003, X01_L = 32'h101;
`else
  localparam int NB = 8;
  localparam logic [31:0] B3_M = 32'hB3, B3_L = 32'hCD, X01_M = 32'h01, X01_L = 32'h80;
`endif
  logic clk = 0, rst = 1, load_valid = 0;
  logic [7:0] load_data = 0;
  logic rdy_m, dout_m, dv_m, busy_m, done_m;
  logic rdy_l, dout_l, dv_l, busy_l, done_l;
  int errors = 0, checks = 0, ndone = 0;
  bit q_m[$], q_l[$];
  logic [31:0] cap_m = 0, cap_l = 0;
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_m),
    .dout(dout_m), .dout_valid(dv_m), .busy(busy_m), .done(done_m));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid), .load_ready(rdy_l),
    .dout(dout_l), .dout_valid(dv_l), .busy(busy_l), .done(done_l));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs;
    chk("dout_m", 32'(dout_m), q_m.size() > 0 ? 32'(q_m[0]) : 0);
    chk("dout_l", 32'(dout_l), q_l.size() > 0 ? 32'(q_l[0]) : 0);
    chk("valid_m", 32'(dv_m), 32'(q_m.size() > 0));
    chk("valid_l", 32'(dv_l), 32'(q_l.size() > 0));
    chk("busy_m", 32'(busy_m), 32'(q_m.size() > 0));
    chk("busy_l", 32'(busy_l), 32'(q_l.size() > 0));
    chk("done_m", 32'(done_m), 32'(q_m.size() == 1));
    chk("done_l", 32'(done_l), 32'(q_l.size() == 1));
    chk("ready_m", 32'(rdy_m), 32'(q_m.size() <= 1));
    chk("ready_l", 32'(rdy_l), 32'(q_l.size() <= 1));
  endtask
  task automatic push(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      q_m.push_back(d[7-i]);
      q_l.push_back(d[i]);
    end
`ifdef PISO_PARITY_EN
    q_m.push_back(^d);
    q_l.push_back(^d);
`endif
  endtask
  task automatic cycle(input logic v, input logic [7:0] d);
    bit rdy;
    @(negedge clk);
    load_valid = v;
    load_data = d;
    check_outs;
    rdy = q_m.size() <= 1;
    if (dv_m) cap_m = {cap_m[30:0], dout_m};
    if (dv_l) cap_l = {cap_l[30:0], dout_l};
    if (done_m) ndone++;
    @(posedge clk);
    if (q_m.size() > 0) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (v && rdy) push(d);
  endtask
  task automatic drain;
    repeat (NB + 2) cycle(0, 8'h00);
  endtask
  task automatic clear_caps;
    cap_m = 0;
    cap_l = 0;
    ndone = 0;
  endtask
  initial begin
    #1;
    check_outs;
    @(negedge clk);
    rst = 0;
    cycle(1, 8'hB3);
    drain;
    chk("b3_m", cap_m & ((32'd1 << NB) - 1), B3_M);
    chk("b3_l", cap_l & ((32'd1 << NB) - 1), B3_L);
    chk("b3_done", ndone, 1);
    clear_caps;
    cycle(1, 8'hA5);
    repeat (NB - 1) cycle(1, 8'h3C);
    cycle(1, 8'h3C);
    drain;
    chk("b2b_done", ndone, 2);
`ifndef PISO_PARITY_EN
    chk("b2b_m", cap_m & 32'hFFFF, 32'hA53C);
`endif
    clear_caps;
    cycle(1, 8'h00);
    repeat (2) cycle(0, 8'h00);
    cycle(1, 8'hFF);
    drain;
    chk("ign_m", cap_m, 0);
    chk("ign_done", ndone, 1);
    clear_caps;
    cycle(1, 8'hB3);
    repeat (3) cycle(0, 8'h00);
    #3;
    rst = 1;
    q_m.delete();
    q_l.delete();
    #1;
    check_outs;
    @(posedge clk);
    #3;
    rst = 0;
    clear_caps;
    cycle(1, 8'h01);
    drain;
    chk("x01_m", cap_m & ((32'd1 << NB) - 1), X01_M);
    chk("x01_l", cap_l & ((32'd1 << NB) - 1), X01_L);
    repeat (400) cycle($urandom_range(0, 3) != 0, 8'($urandom));
    drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
